ocp_burst_slave: RTL

Parametrised OCP slave that bridges one master port to a simple single-port memory interface. It adds programmable-length burst reads and writes with per-beat address increment, an explicit data-phase handshake, and response flow control via MRespAccept. It reports an ERR response for illegal commands, illegal burst lengths and MDataLast framing violations. It sits between the OCP interconnect and a memory controller, selected by a bus id.

---
 rtl/ocp_burst_slave.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ocp_burst_slave.sv
// OCP slave that maps programmable-length burst reads/writes onto a single-port memory.
// A single read is outstanding at a time. ERR is returned for illegal commands, bad lengths and MDataLast framing errors.
module ocp_burst_slave #(
  parameter int                 DATAWIDTH    = 8,
  parameter int                 ADDRESSWIDTH = 32,
  parameter int                 IDWIDTH      = 2,
  parameter logic [IDWIDTH-1:0] ID           = 2'b01,
  parameter int                 MAXBURST     = 8,
  parameter int                 BLWIDTH      = 4,
  parameter int                 ADDR_STEP    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDWIDTH-1:0]      id,
  input  logic [2:0]              MCmd,
  input  logic [ADDRESSWIDTH-1:0] MAddr,
  input  logic [BLWIDTH-1:0]      MBurstLength,
  input  logic [DATAWIDTH-1:0]    MData,
  input  logic                    MDataValid,
  input  logic                    MDataLast,
  input  logic                    MRespAccept,
  output logic                    SCmdAccept,
  output logic                    SDataAccept,
  output logic [1:0]              SResp,
  output logic [DATAWIDTH-1:0]    SData,
  output logic                    SRespLast,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic                    mem_busy,
  input  logic [DATAWIDTH-1:0]    mem_rdata,
  input  logic                    mem_rvalid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_RESP = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [2:0]              CMD_IDLE  = 3'b000;
  localparam logic [2:0]              CMD_WR    = 3'b001;
  localparam logic [2:0]              CMD_RD    = 3'b010;
  localparam logic [1:0]              RESP_NULL = 2'b00;
  localparam logic [1:0]              RESP_DVA  = 2'b01;
  localparam logic [1:0]              RESP_ERR  = 2'b11;
  localparam logic [BLWIDTH-1:0]      MAX_LEN   = BLWIDTH'(MAXBURST);
  localparam logic [BLWIDTH-1:0]      BL_ONE    = BLWIDTH'(1);
  localparam logic [ADDRESSWIDTH-1:0] STEP      = ADDRESSWIDTH'(ADDR_STEP);

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [BLWIDTH-1:0]      len_q, len_d;
  logic [BLWIDTH-1:0]      beat_q, beat_d;
  logic                    err_q, err_d;
  logic [1:0]              resp_q, resp_d;
  logic                    rlast_q, rlast_d;
  logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
  logic [ADDRESSWIDTH-1:0] maddr_q, maddr_d;
  logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    re_q, re_d;
  logic                    cmd_acc_s, data_acc_s, last_beat_s, len_ok_s, frame_err_s;

  assign last_beat_s = (beat_q == (len_q - BL_ONE));
  assign len_ok_s    = (MBurstLength != {BLWIDTH{1'b0}}) && (MBurstLength <= MAX_LEN);
  assign frame_err_s = (MDataLast != last_beat_s);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_d      = err_q;
    resp_d     = resp_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    cmd_acc_s  = 1'b0;
    data_acc_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_acc_s = (MCmd != CMD_IDLE) && (id == ID) && !mem_busy;
        if (cmd_acc_s) begin
          addr_d = MAddr;
          len_d  = MBurstLength;
          beat_d = {BLWIDTH{1'b0}};
          err_d  = 1'b0;
          if (!len_ok_s || ((MCmd != CMD_WR) && (MCmd != CMD_RD))) begin
            err_d   = 1'b1;
            resp_d  = RESP_ERR;
            rlast_d = 1'b1;
            state_d = S_RESP;
          end else if (MCmd == CMD_WR) begin
            state_d = S_WRITE;
          end else begin
            // mem_busy is already known low here, so the first read issues on the accepting edge
            re_d    = 1'b1;
            maddr_d = MAddr;
            state_d = S_RD_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        data_acc_s = MDataValid && !mem_busy;
        if (data_acc_s) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = MData;
          addr_d  = addr_q + STEP;
          beat_d  = beat_q + BL_ONE;
          err_d   = err_q | frame_err_s;
          if (last_beat_s) begin
            resp_d  = (err_q || frame_err_s) ? RESP_ERR : RESP_DVA;
            rlast_d = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_RESP: begin
        if (MRespAccept) begin
          resp_d  = RESP_NULL;
          rlast_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RD_REQ: begin
        if (!mem_busy) begin
          re_d    = 1'b1;
          maddr_d = addr_q;
          state_d = S_RD_WAIT;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          resp_d  = RESP_DVA;
          rlast_d = last_beat_s;
          state_d = S_RD_RESP;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_RESP: begin
        if (MRespAccept) begin
          resp_d  = RESP_NULL;
          rlast_d = 1'b0;
          beat_d  = beat_q + BL_ONE;
          addr_d  = addr_q + STEP;
          state_d = last_beat_s ? S_IDLE : S_RD_REQ;
        end else begin
          state_d = S_RD_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDRESSWIDTH{1'b0}};
      len_q   <= {BLWIDTH{1'b0}};
      beat_q  <= {BLWIDTH{1'b0}};
      err_q   <= 1'b0;
      resp_q  <= RESP_NULL;
      rlast_q <= 1'b0;
      rdata_q <= {DATAWIDTH{1'b0}};
      maddr_q <= {ADDRESSWIDTH{1'b0}};
      wdata_q <= {DATAWIDTH{1'b0}};
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      rlast_q <= rlast_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  assign SCmdAccept  = cmd_acc_s;
  assign SDataAccept = data_acc_s;
  assign SResp       = resp_q;
  assign SRespLast   = rlast_q;
  assign SData       = rdata_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = we_q;
  assign mem_re      = re_q;

endmodule
